// File: rtl/efi_pkg.sv
// Shared register-map constants for the SPI-attached peripheral blocks.
package efi_pkg;

  localparam int SPI_ADDR_W = 7;
  localparam int SPI_DATA_W = 16;

  localparam logic [SPI_ADDR_W-1:0] PWM_BASE = 7'd8;

  // Offsets inside the PWM window; duty registers follow OFF_DUTY0 contiguously
  localparam int OFF_PERIOD = 0;
  localparam int OFF_CTRL   = 1;
  localparam int OFF_DUTY0  = 2;

  localparam int CTRL_RUN = 0;
  localparam int CTRL_IMM = 1;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: duty shadow/active pair, compare against the shared counter, output flop.
module pwm_cmp_ch #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              duty_wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              commit,
  input  logic              enable,
  input  logic [DATA_W-1:0] cnt,
  output logic [DATA_W-1:0] duty_sh,
  output logic              pwm_out
);

  logic [DATA_W-1:0] duty_act;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (duty_wr) duty_sh <= data_in;
      // commit copies the shadow as it stood before any same-edge write
      if (commit) duty_act <= duty_sh;
      pwm_out <= enable && (cnt < duty_act);
    end
  end

endmodule

// File: rtl/spi_pwm_bank.sv
// Register-mapped PWM bank: shared period counter, NUM_CH duty channels, atomic shadow commit.
module spi_pwm_bank
  import efi_pkg::*;
#(
  parameter int                NUM_CH    = 6,
  parameter int                ADDR_W    = SPI_ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(PWM_BASE),
  parameter int                DATA_W    = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              wrap
);

  logic [ADDR_W-1:0] wr_off;
  logic [ADDR_W-1:0] rd_off;
  logic [DATA_W-1:0] period_sh;
  logic [DATA_W-1:0] period_act;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] rd_next;
  logic [DATA_W-1:0] duty_sh [NUM_CH];
  logic [NUM_CH-1:0] duty_wr;
  logic              run;
  logic              imm;
  logic              pending;
  logic              running;
  logic              wrap_evt;
  logic              commit;
  logic              period_wr;
  logic              ctrl_wr;

  assign wr_off    = addr - ADDR_BASE;
  assign rd_off    = rd_addr - ADDR_BASE;
  assign period_wr = wr_en && (wr_off == ADDR_W'(OFF_PERIOD));
  assign ctrl_wr   = wr_en && (wr_off == ADDR_W'(OFF_CTRL));

  // >= rather than == so a period shrunk below the live count wraps at once
  assign running  = run && (period_act != '0);
  assign wrap_evt = running && (cnt >= period_act - DATA_W'(1));
  assign commit   = pending && (wrap_evt || !run || (period_act == '0) || imm);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_sh  <= '0;
      period_act <= '0;
      run        <= 1'b0;
      imm        <= 1'b0;
      pending    <= 1'b0;
      cnt        <= '0;
      wrap       <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (period_wr) period_sh <= data_in;
      if (ctrl_wr) begin
        run <= data_in[CTRL_RUN];
        imm <= data_in[CTRL_IMM];
      end
      if (commit) period_act <= period_sh;
      if (period_wr || (|duty_wr)) pending <= 1'b1;
      else if (commit)             pending <= 1'b0;
      if (!running || wrap_evt) cnt <= '0;
      else                      cnt <= cnt + DATA_W'(1);
      wrap    <= wrap_evt;
      rd_data <= rd_next;
    end
  end

  always_comb begin
    rd_next = '0;
    if (rd_off == ADDR_W'(OFF_PERIOD)) begin
      rd_next = period_sh;
    end else if (rd_off == ADDR_W'(OFF_CTRL)) begin
      rd_next[CTRL_RUN] = run;
      rd_next[CTRL_IMM] = imm;
    end else if (rd_off == ADDR_W'(OFF_DUTY0 + NUM_CH)) begin
      rd_next = cnt;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_off == ADDR_W'(OFF_DUTY0 + i)) rd_next = duty_sh[i];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign duty_wr[i] = wr_en && (wr_off == ADDR_W'(OFF_DUTY0 + i));

    pwm_cmp_ch #(.DATA_W(DATA_W)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .duty_wr (duty_wr[i]),
      .data_in (data_in),
      .commit  (commit),
      .enable  (running),
      .cnt     (cnt),
      .duty_sh (duty_sh[i]),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Bench for spi_pwm_bank: register table, directed period sequences, randomized run vs reference model.
module tb_spi_pwm_bank;

  localparam int NUM_CH = 6;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int BASE   = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              wrap;

  always #5 clk = ~clk;

  spi_pwm_bank #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .ADDR_BASE (7'd8),
    .DATA_W    (DATA_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .addr    (addr),
    .data_in (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .pwm_out (pwm_out),
    .wrap    (wrap)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, in plain integers
  int          m_psh, m_pact, m_cnt, m_rd;
  bit          m_run, m_imm, m_pend, m_wrap;
  int          m_dsh  [NUM_CH];
  int          m_dact [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;

  function automatic int map_read(input int a);
    int off;
    off = a - BASE;
    if (off == 0) return m_psh;
    if (off == 1) return int'(m_run) + 2 * int'(m_imm);
    if (off >= 2 && off < NUM_CH + 2) return m_dsh[off-2];
    if (off == NUM_CH + 2) return m_cnt;
    return 0;
  endfunction

  task automatic model_edge();
    bit live, we, com;
    int off;
    if (!reset_n) begin
      m_psh = 0; m_pact = 0; m_cnt = 0; m_rd = 0;
      m_run = 0; m_imm = 0; m_pend = 0; m_wrap = 0; m_pwm = '0;
      for (int i = 0; i < NUM_CH; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
    end else begin
      live = m_run && (m_pact != 0);
      we   = live && (m_cnt >= m_pact - 1);
      com  = we || !m_run || (m_pact == 0) || m_imm;
      off  = int'(addr) - BASE;
      for (int i = 0; i < NUM_CH; i++) m_pwm[i] = live && (m_cnt < m_dact[i]);
      m_rd   = map_read(int'(rd_addr));
      m_wrap = we;
      m_cnt  = (live && !we) ? m_cnt + 1 : 0;
      if (com && m_pend) begin
        m_pact = m_psh;
        for (int i = 0; i < NUM_CH; i++) m_dact[i] = m_dsh[i];
        m_pend = 0;
      end
      if (wr_en) begin
        if (off == 0) begin
          m_psh = int'(data_in); m_pend = 1;
        end else if (off == 1) begin
          m_run = data_in[0]; m_imm = data_in[1];
        end else if (off >= 2 && off < NUM_CH + 2) begin
          m_dsh[off-2] = int'(data_in); m_pend = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== m_pwm || wrap !== m_wrap || rd_data !== DATA_W'(m_rd)) begin
      errors++;
      $display("FAIL model t=%0t pwm=%b exp %b wrap=%b exp %b rd_data=%h exp %h",
               $time, pwm_out, m_pwm, wrap, m_wrap, rd_data, DATA_W'(m_rd));
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; addr = ADDR_W'(a); data_in = DATA_W'(d);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic align(input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      cycle();
      if (wrap === 1'b1) seen = 1;
    end
    check(name, int'(seen), 1);
  endtask

  // Ten cycles of a PERIOD=10 frame, starting right after a wrap sample;
  // up to two DUTY0 writes at chosen cycle indices (0 = none).
  task automatic run_period(input int k1, input int v1, input int k2, input int v2,
                            output int h0, output int h1, output int h2, output int nw);
    h0 = 0; h1 = 0; h2 = 0; nw = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == k1) begin wr_en = 1'b1; addr = ADDR_W'(BASE + 2); data_in = DATA_W'(v1); end
      if (k == k2) begin wr_en = 1'b1; addr = ADDR_W'(BASE + 2); data_in = DATA_W'(v2); end
      cycle();
      wr_en = 1'b0;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      nw += int'(wrap);
    end
  endtask

  typedef struct {
    int wa;
    int wd;
    int ra;
    int exp_rd;
  } reg_vec_t;

  reg_vec_t vecs [11];

  initial begin
    int h0, h1, h2, nw;

    vecs[0]  = '{BASE + 0,  'h1234, BASE + 0,  'h1234};
    vecs[1]  = '{BASE + 1,  'hFFFC, BASE + 1,  0};
    vecs[2]  = '{BASE + 1,  'h0002, BASE + 1,  2};
    vecs[3]  = '{BASE + 2,  'hABCD, BASE + 2,  'hABCD};
    vecs[4]  = '{BASE + 7,  'h0055, BASE + 7,  'h0055};
    vecs[5]  = '{BASE + 8,  'h7777, BASE + 8,  0};
    vecs[6]  = '{BASE + 9,  'h1111, BASE + 9,  0};
    vecs[7]  = '{BASE - 1,  'h2222, BASE - 1,  0};
    vecs[8]  = '{BASE - 1,  'h2222, BASE + 0,  'h1234};
    vecs[9]  = '{BASE + 9,  'h3333, BASE + 7,  'h0055};
    vecs[10] = '{BASE + 1,  'h0000, BASE + 1,  0};

    reset_n = 1'b0; wr_en = 1'b0; addr = '0; data_in = '0; rd_addr = ADDR_W'(BASE);
    cycle();
    cycle();
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_rd", int'(rd_data), 0);
    reset_n = 1'b1;

    // Register write/readback table
    for (int v = 0; v < 11; v++) begin
      rd_addr = ADDR_W'(vecs[v].ra);
      wr(vecs[v].wa, vecs[v].wd);
      cycle();
      check($sformatf("regmap[%0d]", v), int'(rd_data), vecs[v].exp_rd);
    end

    // Basic waveform plus constant-low / constant-high channels
    wr(BASE + 0, 10);
    wr(BASE + 2, 3);
    wr(BASE + 3, 0);
    wr(BASE + 4, 20);
    wr(BASE + 1, 1);
    align("align_basic");
    for (int p = 0; p < 2; p++) begin
      run_period(0, 0, 0, 0, h0, h1, h2, nw);
      check("basic_high_ch0", h0, 3);
      check("basic_ch1_low", h1, 0);
      check("basic_ch2_high", h2, 10);
      check("basic_wrap_count", nw, 1);
    end

    // Mid-period duty write takes effect from the next frame
    run_period(5, 7, 0, 0, h0, h1, h2, nw);
    check("midwrite_cur", h0, 3);
    run_period(0, 0, 0, 0, h0, h1, h2, nw);
    check("midwrite_next", h0, 7);

    // Write landing on the wrap edge: pre-write shadow commits, new value one frame later
    run_period(3, 5, 0, 0, h0, h1, h2, nw);
    check("wrapwr_a", h0, 7);
    run_period(4, 6, 10, 2, h0, h1, h2, nw);
    check("wrapwr_b", h0, 5);
    run_period(0, 0, 0, 0, h0, h1, h2, nw);
    check("wrapwr_c_old_shadow", h0, 6);
    run_period(0, 0, 0, 0, h0, h1, h2, nw);
    check("wrapwr_d_new", h0, 2);
    check("wrapwr_wrap_count", nw, 1);

    // Immediate mode
    wr(BASE + 1, 3);
    rd_addr = ADDR_W'(BASE + 2);
    wr(BASE + 2, 5);
    cycle();
    check("imm_readback", int'(rd_data), 5);
    wr(BASE + 2, 0);
    cycle();
    h0 = 0;
    for (int k = 0; k < 10; k++) begin cycle(); h0 += int'(pwm_out[0]); end
    check("imm_duty0", h0, 0);
    wr(BASE + 2, 20);
    cycle();
    h0 = 0;
    for (int k = 0; k < 10; k++) begin cycle(); h0 += int'(pwm_out[0]); end
    check("imm_duty20", h0, 10);

    // Reset mid-period, with a colliding write
    wr(BASE + 1, 1);
    rd_addr = ADDR_W'(BASE);
    for (int k = 0; k < 4; k++) cycle();
    reset_n = 1'b0; wr_en = 1'b1; addr = ADDR_W'(BASE); data_in = 16'd99;
    cycle();
    reset_n = 1'b1; wr_en = 1'b0;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_rd", int'(rd_data), 0);
    for (int a = BASE; a <= BASE + NUM_CH + 2; a++) begin
      rd_addr = ADDR_W'(a);
      cycle();
      check($sformatf("rst_read[%0d]", a), int'(rd_data), 0);
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int off;
      reset_n = ($urandom_range(0, 299) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      off     = int'($urandom_range(0, 12)) - 2;
      addr    = ADDR_W'(BASE + off);
      if (off == 1) begin
        data_in = DATA_W'($urandom) & 16'hFFFC;
        data_in[0] = ($urandom_range(0, 4) != 0);
        data_in[1] = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 7) == 0) begin
        data_in = DATA_W'($urandom);
      end else begin
        data_in = DATA_W'($urandom_range(0, 16));
      end
      rd_addr = ADDR_W'($urandom_range(BASE - 2, BASE + 10));
      cycle();
    end
    reset_n = 1'b1; wr_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
